// File: rtl/loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states,
// terminator defaults, acknowledge byte and error flag positions.
package loader_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      WRITE   = 2'd1,
      ACK     = 2'd2,
      DONE    = 2'd3
   } loader_state_e;

   localparam logic [7:0]  ACK_TERM         = 8'h55;
   localparam logic [15:0] DEFAULT_END_ADDR = 16'h00FF;
   localparam logic [15:0] DEFAULT_END_DATA = 16'h00FF;

   localparam int ERR_OVERRUN = 0;
   localparam int ERR_TIMEOUT = 1;

   // Acknowledge byte for a normal record: XOR of its four bytes.
   function automatic logic [7:0] record_xor(input logic [31:0] rec);
      return rec[7:0] ^ rec[15:8] ^ rec[23:16] ^ rec[31:24];
   endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Counts idle cycles between bytes of a record; pulses expired for one
// cycle when the gap reaches TIMEOUT_CYCLES unless restart arrives first.
module byte_gap_timer #(
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic restart,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // A byte in the expiry cycle takes priority, so restart masks expired.
   always_comb begin
      cnt_d   = cnt_q;
      expired = 1'b0;
      if (!enable || restart) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d   = '0;
         expired = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_word_loader.sv
// Boot loader: assembles UART bytes into {data, address} records, writes
// them to program memory, acknowledges each, and stops on the terminator.
module uart_word_loader
   import loader_pkg::*;
#(
   parameter int          TIMEOUT_CYCLES = 100000,
   parameter logic [15:0] END_ADDR       = DEFAULT_END_ADDR,
   parameter logic [15:0] END_DATA       = DEFAULT_END_DATA
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        tx_busy,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_data,
   output logic        mem_we,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   output logic        load_done,
   output logic [1:0]  byte_count,
   output logic [1:0]  err
);

   loader_state_e    state_q, state_d;
   logic [3:0][7:0]  rec_q, rec_d;
   logic [1:0]       byte_count_q, byte_count_d;
   logic [15:0]      mem_addr_q, mem_addr_d;
   logic [15:0]      mem_data_q, mem_data_d;
   logic             mem_we_q, mem_we_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_valid_q, tx_valid_d;
   logic             load_done_q, load_done_d;
   logic [1:0]       err_q, err_d;
   logic             term_q, term_d;

   logic             gap_enable;
   logic             gap_expired;
   logic [31:0]      rec_full;
   logic             rec_is_term;

   assign gap_enable = (state_q == COLLECT) && (byte_count_q != 2'd0);

   byte_gap_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_gap_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (gap_enable),
      .restart (rx_valid),
      .expired (gap_expired)
   );

   // Complete record as it will look once the final byte is stored.
   assign rec_full    = {rx_data, rec_q[2], rec_q[1], rec_q[0]};
   assign rec_is_term = (rec_full[15:0] == END_ADDR) && (rec_full[31:16] == END_DATA);

   // Memory and ack outputs are registered on entry to WRITE so they are
   // valid during the WRITE cycle itself.
   always_comb begin
      state_d      = state_q;
      rec_d        = rec_q;
      byte_count_d = byte_count_q;
      mem_addr_d   = mem_addr_q;
      mem_data_d   = mem_data_q;
      mem_we_d     = 1'b0;
      tx_data_d    = tx_data_q;
      tx_valid_d   = tx_valid_q;
      load_done_d  = load_done_q;
      err_d        = err_q;
      term_d       = term_q;

      case (state_q)
         COLLECT: begin
            if (rx_valid) begin
               rec_d[byte_count_q] = rx_data;
               byte_count_d        = byte_count_q + 2'd1;
               if (byte_count_q == 2'd3) begin
                  state_d = WRITE;
                  term_d  = rec_is_term;
                  if (rec_is_term) begin
                     tx_data_d = ACK_TERM;
                  end else begin
                     mem_addr_d = rec_full[15:0];
                     mem_data_d = rec_full[31:16];
                     mem_we_d   = 1'b1;
                     tx_data_d  = record_xor(rec_full);
                  end
               end
            end else if (gap_expired) begin
               byte_count_d       = 2'd0;
               rec_d              = '0;
               err_d[ERR_TIMEOUT] = 1'b1;
            end
         end

         WRITE: begin
            tx_valid_d = 1'b1;
            state_d    = ACK;
            if (rx_valid) begin
               err_d[ERR_OVERRUN] = 1'b1;
            end
         end

         ACK: begin
            if (rx_valid) begin
               err_d[ERR_OVERRUN] = 1'b1;
            end
            if (tx_valid_q && !tx_busy) begin
               tx_valid_d  = 1'b0;
               load_done_d = term_q;
               state_d     = term_q ? DONE : COLLECT;
            end
         end

         DONE: begin
            tx_valid_d = 1'b0;
         end

         default: begin
            state_d = COLLECT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= COLLECT;
         rec_q        <= '0;
         byte_count_q <= 2'd0;
         mem_addr_q   <= 16'd0;
         mem_data_q   <= 16'd0;
         mem_we_q     <= 1'b0;
         tx_data_q    <= 8'd0;
         tx_valid_q   <= 1'b0;
         load_done_q  <= 1'b0;
         err_q        <= 2'b00;
         term_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         rec_q        <= rec_d;
         byte_count_q <= byte_count_d;
         mem_addr_q   <= mem_addr_d;
         mem_data_q   <= mem_data_d;
         mem_we_q     <= mem_we_d;
         tx_data_q    <= tx_data_d;
         tx_valid_q   <= tx_valid_d;
         load_done_q  <= load_done_d;
         err_q        <= err_d;
         term_q       <= term_d;
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_data   = mem_data_q;
   assign mem_we     = mem_we_q;
   assign tx_data    = tx_data_q;
   assign tx_valid   = tx_valid_q;
   assign load_done  = load_done_q;
   assign byte_count = byte_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Directed bench for uart_word_loader: table of normal records plus
// hand-written sequences for backpressure, timeout, reset and terminator.
module tb_uart_word_loader;
   import loader_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        tx_busy;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_we;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        load_done;
   logic [1:0]  byte_count;
   logic [1:0]  err;

   int n_chk;
   int n_fail;
   int we_cnt;

   uart_word_loader #(
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .tx_busy    (tx_busy),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .mem_we     (mem_we),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .load_done  (load_done),
      .byte_count (byte_count),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Write strobes counted on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) we_cnt = we_cnt + 1;
   end

   typedef struct {
      logic [31:0] bytes;     // byte 0 sent first, from bits [7:0]
      logic [15:0] exp_addr;
      logic [15:0] exp_data;
      logic [7:0]  exp_ack;
   } rec_vec_t;

   rec_vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_record(input logic [31:0] bytes);
      for (int j = 0; j < 4; j++) begin
         send_byte(bytes[8*j +: 8]);
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, ".mem_addr"},   32'(mem_addr),   32'h0);
      chk({tag, ".mem_data"},   32'(mem_data),   32'h0);
      chk({tag, ".mem_we"},     32'(mem_we),     32'h0);
      chk({tag, ".tx_data"},    32'(tx_data),    32'h0);
      chk({tag, ".tx_valid"},   32'(tx_valid),   32'h0);
      chk({tag, ".load_done"},  32'(load_done),  32'h0);
      chk({tag, ".byte_count"}, 32'(byte_count), 32'h0);
      chk({tag, ".err"},        32'(err),        32'h0);
   endtask

   // Sends a record with tx_busy low and checks write, ack and return.
   task automatic run_record(input string tag, input logic [31:0] bytes,
                             input logic [15:0] ea, input logic [15:0] ed,
                             input logic [7:0] ack);
      int we0;
      we0 = we_cnt;
      send_record(bytes);
      chk({tag, ".we"},    32'(mem_we),   32'h1);
      chk({tag, ".addr"},  32'(mem_addr), 32'(ea));
      chk({tag, ".data"},  32'(mem_data), 32'(ed));
      chk({tag, ".ack"},   32'(tx_data),  32'(ack));
      tick();
      chk({tag, ".we_off"},  32'(mem_we),   32'h0);
      chk({tag, ".txv"},     32'(tx_valid), 32'h1);
      tick();
      chk({tag, ".txv_off"}, 32'(tx_valid),   32'h0);
      chk({tag, ".bc"},      32'(byte_count), 32'h0);
      chk({tag, ".we_cnt"},  32'(we_cnt - we0), 32'h1);
   endtask

   initial begin
      int we0;
      n_chk    = 0;
      n_fail   = 0;
      we_cnt   = 0;
      rst_n    = 1'b0;
      rx_data  = 8'h00;
      rx_valid = 1'b0;
      tx_busy  = 1'b0;

      vecs[0] = '{32'h1234_0010, 16'h0010, 16'h1234, 8'h36};
      vecs[1] = '{32'hF00F_55AA, 16'h55AA, 16'hF00F, 8'h00};
      vecs[2] = '{32'h7FFF_8001, 16'h8001, 16'h7FFF, 8'h01};
      vecs[3] = '{32'h00FE_00FF, 16'h00FF, 16'h00FE, 8'h01};
      vecs[4] = '{32'h00FF_00FE, 16'h00FE, 16'h00FF, 8'h01};

      repeat (2) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 5; i++) begin
         run_record($sformatf("vec%0d", i), vecs[i].bytes,
                    vecs[i].exp_addr, vecs[i].exp_data, vecs[i].exp_ack);
      end
      chk("vec.err", 32'(err), 32'h0);

      // Ack held off by a busy transmitter; a byte arriving in ACK is dropped.
      tx_busy = 1'b1;
      we0 = we_cnt;
      send_record(32'hAB00_3420);
      chk("bp.addr", 32'(mem_addr), 32'h3420);
      chk("bp.data", 32'(mem_data), 32'hAB00);
      tick();
      for (int i = 0; i < 20; i++) begin
         chk($sformatf("bp.txv%0d", i), 32'(tx_valid), 32'h1);
         chk($sformatf("bp.txd%0d", i), 32'(tx_data),  32'hBF);
         if (i == 5) begin
            rx_data  = 8'hEE;
            rx_valid = 1'b1;
         end
         tick();
         rx_valid = 1'b0;
      end
      chk("bp.overrun", 32'(err), 32'h1);
      chk("bp.bc",      32'(byte_count), 32'h0);
      tx_busy = 1'b0;
      chk("bp.txv_hold", 32'(tx_valid), 32'h1);
      tick();
      chk("bp.txv_off", 32'(tx_valid), 32'h0);
      chk("bp.bc_after", 32'(byte_count), 32'h0);
      chk("bp.we_cnt",   32'(we_cnt - we0), 32'h1);
      run_record("bp.next", 32'h1234_0010, 16'h0010, 16'h1234, 8'h36);
      chk("bp.err_sticky", 32'(err), 32'h1);

      // Gap timeout after two bytes.
      apply_reset();
      chk("to.err_rst", 32'(err), 32'h0);
      send_byte(8'hA1);
      send_byte(8'hA2);
      repeat (15) tick();
      chk("to.pre_err", 32'(err), 32'h0);
      chk("to.pre_bc",  32'(byte_count), 32'h2);
      tick();
      chk("to.err", 32'(err), 32'h2);
      chk("to.bc",  32'(byte_count), 32'h0);
      run_record("to.next", 32'h1234_0010, 16'h0010, 16'h1234, 8'h36);

      // Byte arriving exactly in the expiry cycle wins.
      apply_reset();
      send_byte(8'h44);
      send_byte(8'h33);
      repeat (15) tick();
      send_byte(8'h22);
      chk("tie.err", 32'(err), 32'h0);
      chk("tie.bc",  32'(byte_count), 32'h3);
      send_byte(8'h11);
      chk("tie.we",   32'(mem_we),   32'h1);
      chk("tie.addr", 32'(mem_addr), 32'h3344);
      chk("tie.data", 32'(mem_data), 32'h1122);
      chk("tie.ack",  32'(tx_data),  32'h44);
      repeat (2) tick();

      // Reset while the ack is pending.
      tx_busy = 1'b1;
      send_record(32'h0000_0102);
      tick();
      chk("rack.txv", 32'(tx_valid), 32'h1);
      apply_reset();
      chk_all_zero("rack");
      tx_busy = 1'b0;
      run_record("rack.next", 32'hF00F_55AA, 16'h55AA, 16'hF00F, 8'h00);

      // Terminator record, then traffic after load_done is ignored.
      we0 = we_cnt;
      send_record(32'h00FF_00FF);
      chk("term.we",  32'(mem_we),  32'h0);
      chk("term.ack", 32'(tx_data), 32'(ACK_TERM));
      tick();
      chk("term.txv", 32'(tx_valid), 32'h1);
      chk("term.ld_pre", 32'(load_done), 32'h0);
      tick();
      chk("term.ld",      32'(load_done), 32'h1);
      chk("term.txv_off", 32'(tx_valid),  32'h0);
      send_record(32'h1234_0010);
      send_record(32'h5678_0020);
      repeat (3) tick();
      chk("done.we_cnt", 32'(we_cnt - we0), 32'h0);
      chk("done.err",    32'(err),       32'h0);
      chk("done.txv",    32'(tx_valid),  32'h0);
      chk("done.ld",     32'(load_done), 32'h1);
      chk("done.bc",     32'(byte_count), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_word_loader.md
# uart_word_loader

- Boot-time loader that sits directly downstream of the UART receiver.
- Collects received bytes into 4-byte {data, address} records and writes each record into CPU program memory with a single-cycle strobe.
- Returns a per-record acknowledge byte through the UART transmitter.
- On the terminator record (address 0x00FF, data 0x00FF) it stops loading and raises `load_done`, which hands memory ownership to the CPU.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 100000: maximum idle gap between bytes of one record, in clk cycles.
- `END_ADDR`, 16'h00FF: terminator address.
- `END_DATA`, 16'h00FF: terminator data.

Ports:
- `clk` in 1: single clock; everything is posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is valid in that cycle.
- `tx_busy` in 1: UART transmitter busy.
- `mem_addr` out 16: program memory write address.
- `mem_data` out 16: program memory write data.
- `mem_we` out 1: one-cycle write strobe.
- `tx_data` out 8: acknowledge byte.
- `tx_valid` out 1: acknowledge request.
- `load_done` out 1: loading finished; held until reset.
- `byte_count` out 2: index of the next byte expected within the record.
- `err` out 2: sticky flags; bit 0 = overrun, bit 1 = timeout.

## Operation
- States: COLLECT, WRITE, ACK, DONE.
- Reset:
  - state = COLLECT.
  - Outputs zero: `mem_addr`, `mem_data`, `mem_we`, `tx_data`, `tx_valid`, `load_done`, `byte_count`, `err`.
  - Record buffer and gap counter cleared.
- COLLECT: on `rx_valid`, store the byte at `buf[byte_count]` and increment `byte_count` (mod 4).
  - Byte order: `buf[0]` = addr[7:0], `buf[1]` = addr[15:8], `buf[2]` = data[7:0], `buf[3]` = data[15:8].
  - When `byte_count` is 3 and `rx_valid` arrives, go to WRITE; `byte_count` wraps to 0.
- WRITE, lasts one cycle:
  - Normal record:
    - `mem_addr` = {buf[1], buf[0]}.
    - `mem_data` = {buf[3], buf[2]}.
    - `mem_we` = 1.
    - `tx_data` = buf[0] ^ buf[1] ^ buf[2] ^ buf[3].
  - Terminator record:
    - `mem_we` stays 0.
    - `tx_data` = 8'h55.
  - Next state: ACK.
- ACK:
  - `tx_valid` = 1 and `tx_data` stable.
  - The byte is accepted in the first cycle where `tx_valid` = 1 and `tx_busy` = 0.
  - After acceptance, `tx_valid` drops the next cycle.
  - Then go to COLLECT, or to DONE if the record was the terminator.
- DONE:
  - `load_done` = 1.
  - `rx_valid` is ignored and raises no error.
  - `mem_we` and `tx_valid` stay 0 until `rst_n` is asserted low.
- Gap timeout:
  - Active only in COLLECT with `byte_count` ≠ 0.
  - The gap counter increments every cycle and clears on `rx_valid`.
  - On reaching `TIMEOUT_CYCLES` - 1: `byte_count` returns to 0, the partial record is discarded, `err[1]` is set, and the counter clears.
  - If `rx_valid` arrives in the expiry cycle, the byte wins and the timeout does not fire.
- Overrun: `rx_valid` in WRITE or ACK drops the byte and sets `err[0]`.
- Errors are sticky and do not block loading; only reset clears them.
- Reset mid-record or mid-ACK: all state is lost, and `tx_valid` / `mem_we` deassert in the cycle after the reset edge.

## Timing
- Final byte strobe at cycle N:
  - WRITE in N+1; `mem_we`, `mem_addr` and `mem_data` are valid during N+1.
  - `tx_valid` is high from N+2.
- Best-case record turnaround: COLLECT is re-entered at N+3 when `tx_busy` = 0 at N+2.
- `load_done` rises the cycle after the terminator ack is accepted.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `loader_pkg` holds:
  - state enum (COLLECT, WRITE, ACK, DONE);
  - `ACK_TERM` = 8'h55;
  - default `END_ADDR` / `END_DATA` constants;
  - `err` bit indices.
- One sub-module, `byte_gap_timer`:
  - Inputs: `clk`, `rst_n`, `enable`, `restart`.
  - Output: one-cycle `expired`.
  - Parameter: `TIMEOUT_CYCLES`.
  - Counter width = $clog2(`TIMEOUT_CYCLES`).

## Test plan
- Normal record: bytes 0x10, 0x00, 0x34, 0x12 with `tx_busy` = 0 → one `mem_we` with addr 0x0010 / data 0x1234; `tx_data` = 0x36; back in COLLECT with `byte_count` = 0.
- Terminator: bytes 0xFF, 0x00, 0xFF, 0x00 → no `mem_we`; `tx_data` = 0x55; `load_done` = 1; further `rx_valid` produces no writes and no `err` change.
- Ack backpressure: `tx_busy` held 1 for 20 cycles in ACK → `tx_valid` and `tx_data` stable throughout; one acceptance; a byte sent during ACK sets `err[0]` and is dropped.
- Timeout, with `TIMEOUT_CYCLES` = 16: two bytes, then idle 16 cycles → `err[1]` = 1 and `byte_count` = 0; a following 4-byte record is written correctly.
- Timeout tie: `rx_valid` lands exactly in the expiry cycle → byte accepted and `err[1]` stays 0.
- Reset mid-ACK: `rst_n` = 0 while `tx_valid` = 1 → next cycle all outputs are 0 and state is COLLECT.
